aes_round_ctrl: RTL and testbench

//  Sequencer for the AES-128 encryption datapath. Owns the 128-bit state register and steps
//  it through initial AddRoundKey, then NUM_ROUNDS rounds of SubBytes/ShiftRows/MixColumns/

---
 rtl/aes_round_ctrl.sv | 133 +++++++++++++
 tb/tb_aes_round_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequencer for an AES-128 encryption datapath.
// Holds the 128-bit state register and walks it through the initial
// AddRoundKey followed by NUM_ROUNDS rounds of SubBytes / ShiftRows /
// MixColumns / AddRoundKey. MixColumns is skipped in the final round.
// The sub-blocks are external and combinational. They see state_q on
// step_data, and this block captures their result when it is in the
// matching state. Round keys arrive over a key_req/key_valid handshake.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   start, data_in           launch encryption of data_in (only seen in IDLE)
//   busy, done, data_out     status, one-cycle done pulse, state register
//   step_data                operand to the sub-blocks (= state register)
//   subbytes/shiftrow/mixcol_enable  one-hot step strobes (SUB/SHIFT/MIX)
//   sb/sr/mc_result          sub-block results for step_data
//   key_req, round_num       key request for round index round_num
//   key_in, key_valid        round key and its qualifier
module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] data_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] data_out,
  output logic [127:0] step_data,
  output logic         subbytes_enable,
  output logic         shiftrow_enable,
  output logic         mixcol_enable,
  input  logic [127:0] sb_result,
  input  logic [127:0] sr_result,
  input  logic [127:0] mc_result,
  output logic         key_req,
  output logic [3:0]   round_num,
  input  logic [127:0] key_in,
  input  logic         key_valid
);

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  typedef enum logic [2:0] {
    IDLE, KEY0, SUB, SHIFT, MIX, ARK, DONE
  } fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   round_q, round_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    fsm_d           = fsm_q;
    state_d         = state_q;
    round_d         = round_q;
    busy            = 1'b1;
    done            = 1'b0;
    subbytes_enable = 1'b0;
    shiftrow_enable = 1'b0;
    mixcol_enable   = 1'b0;
    key_req         = 1'b0;
    case (fsm_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = data_in;
          round_d = '0;
          fsm_d   = KEY0;
        end
      end
      KEY0: begin
        key_req = 1'b1;
        if (key_valid) begin
          state_d = state_q ^ key_in;
          round_d = 4'd1;
          fsm_d   = SUB;
        end
      end
      SUB: begin
        subbytes_enable = 1'b1;
        state_d         = sb_result;
        fsm_d           = SHIFT;
      end
      SHIFT: begin
        shiftrow_enable = 1'b1;
        state_d         = sr_result;
        // final round goes straight to AddRoundKey without MixColumns
        fsm_d           = (round_q < LAST) ? MIX : ARK;
      end
      MIX: begin
        mixcol_enable = 1'b1;
        state_d       = mc_result;
        fsm_d         = ARK;
      end
      ARK: begin
        key_req = 1'b1;
        if (key_valid) begin
          state_d = state_q ^ key_in;
          if (round_q == LAST) begin
            fsm_d = DONE;
          end else begin
            round_d = round_q + 4'd1;
            fsm_d   = SUB;
          end
        end
      end
      DONE: begin
        done  = 1'b1;
        fsm_d = IDLE;
      end
      default: begin
        busy  = 1'b0;
        fsm_d = IDLE;
      end
    endcase
  end

  assign data_out  = state_q;
  assign step_data = state_q;
  assign round_num = round_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT (10 rounds)
  logic         rst, start, key_valid;
  logic [127:0] data_in, key_in, sb_result, sr_result, mc_result;
  logic         busy, done, sbe, sre, mce, key_req;
  logic [127:0] data_out, step_data;
  logic [3:0]   round_num;

  // second DUT (1 round)
  logic         start1;
  logic         busy1, done1, sbe1, sre1, mce1, key_req1;
  logic [127:0] data_out1, step_data1, sb1, sr1, mc1, key_in1;
  logic [3:0]   round_num1;

  aes_round_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .busy(busy), .done(done), .data_out(data_out), .step_data(step_data),
    .subbytes_enable(sbe), .shiftrow_enable(sre), .mixcol_enable(mce),
    .sb_result(sb_result), .sr_result(sr_result), .mc_result(mc_result),
    .key_req(key_req), .round_num(round_num), .key_in(key_in), .key_valid(key_valid)
  );

  aes_round_ctrl #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .data_in(data_in),
    .busy(busy1), .done(done1), .data_out(data_out1), .step_data(step_data1),
    .subbytes_enable(sbe1), .shiftrow_enable(sre1), .mixcol_enable(mce1),
    .sb_result(sb1), .sr_result(sr1), .mc_result(mc1),
    .key_req(key_req1), .round_num(round_num1), .key_in(key_in1), .key_valid(1'b1)
  );

  // ---------------- reference AES model ----------------
  logic [7:0]   sbox [256];
  logic [127:0] rk   [16];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] f_sub(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox[gb(s, i)];
    return r;
  endfunction

  function automatic logic [127:0] f_shift(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(w+4*c) -: 8] = gb(s, w + 4*((c+w)%4));
    return r;
  endfunction

  function automatic logic [127:0] f_mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
      r[127-8*(4*c)   -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      r[127-8*(4*c+1) -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      r[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      r[127-8*(4*c+3) -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      if (x == 0) inv = 8'h00;
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x] = s;
    end
  endtask

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = '0;
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input int nr);
    logic [127:0] s = pt ^ rk[0];
    for (int r = 1; r <= nr; r++) begin
      s = f_shift(f_sub(s));
      if (r < nr) s = f_mix(s);
      s = s ^ rk[r];
    end
    return s;
  endfunction

  assign sb_result = f_sub(step_data);
  assign sr_result = f_shift(step_data);
  assign mc_result = f_mix(step_data);
  assign key_in    = rk[round_num];
  assign sb1       = f_sub(step_data1);
  assign sr1       = f_shift(step_data1);
  assign mc1       = f_mix(step_data1);
  assign key_in1   = rk[round_num1];

  // ---------------- key_valid driver + monitor ----------------
  int wait_n = 0, wcnt = 0;
  int sb_n, sr_n, mc_n, kh_n, ovl_n, done_n, hold_bad;
  logic         prev_kr = 1'b0, prev_kv = 1'b0;
  logic [127:0] prev_do;
  logic [3:0]   prev_rn;

  always @(negedge clk) begin
    if (wait_n == 0) key_valid = 1'b1;   // tied high: also exercises key_valid outside key_req
    else if (key_req) begin
      if (wcnt < wait_n) begin key_valid = 1'b0; wcnt++; end
      else begin key_valid = 1'b1; wcnt = 0; end
    end else begin
      key_valid = 1'b0; wcnt = 0;
    end
    if (prev_kr && !prev_kv && key_req && !rst)
      if (data_out !== prev_do || round_num !== prev_rn) hold_bad++;
    prev_kr = key_req; prev_kv = key_valid; prev_do = data_out; prev_rn = round_num;
    sb_n += int'(sbe); sr_n += int'(sre); mc_n += int'(mce);
    if (int'(sbe) + int'(sre) + int'(mce) > 1) ovl_n++;
    if (key_req && key_valid) kh_n++;
    if (done) done_n++;
  end

  // ---------------- checking ----------------
  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clr_counts();
    sb_n = 0; sr_n = 0; mc_n = 0; kh_n = 0; ovl_n = 0; done_n = 0; hold_bad = 0;
  endtask

  // start at a negedge; cycle 1 is the cycle after the start-sampling edge
  task automatic run(input logic [127:0] pt, input int wn, input int pa, input int pb,
                     input int pc, output logic [127:0] ct, output int cyc);
    @(negedge clk);
    wait_n = wn; clr_counts();
    data_in = pt; start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      start = (cyc == pa || cyc == pb || cyc == pc);
    end while (!done && cyc < 300);
    ct = data_out;
    @(negedge clk);
    start = 1'b0;
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t         vt [3];
  logic [127:0] ct;
  int           cyc;
  logic [4:0]   sig_exp [5];

  initial begin
    vt[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
              128'h3925841d02dc09fbdc118597196a0b32};
    vt[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vt[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    sig_exp[0] = 5'b10000; sig_exp[1] = 5'b01000; sig_exp[2] = 5'b00100;
    sig_exp[3] = 5'b10000; sig_exp[4] = 5'b00001;

    rst = 1'b1; start = 1'b0; start1 = 1'b0; data_in = '0;
    build_sbox();
    load_key(vt[0].key);
    #23;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_data", data_out, 128'(0));
    chk("rst_round", 128'(round_num), 128'(0));
    chk("rst_strobes", 128'({key_req, sbe, sre, mce}), 128'(0));
    @(negedge clk); rst = 1'b0;

    // table-driven: known-answer vectors, key_valid tied high
    for (int v = 0; v < 3; v++) begin
      load_key(vt[v].key);
      run(vt[v].pt, 0, 0, 0, 0, ct, cyc);
      chk($sformatf("vec%0d_ct", v), ct, vt[v].ct);
      chk($sformatf("vec%0d_cyc", v), 128'(cyc), 128'(41));
      if (v == 0) begin
        chk("cov_mix", 128'(mc_n), 128'(9));
        chk("cov_sub", 128'(sb_n), 128'(10));
        chk("cov_shift", 128'(sr_n), 128'(10));
        chk("cov_keyhs", 128'(kh_n), 128'(11));
        chk("cov_overlap", 128'(ovl_n), 128'(0));
      end
    end
    chk("idle_hold_ct", data_out, vt[2].ct);
    chk("idle_busy", 128'(busy), 128'(0));

    // key_valid held off 3 cycles at every request
    load_key(vt[0].key);
    run(vt[0].pt, 3, 0, 0, 0, ct, cyc);
    chk("wait_ct", ct, vt[0].ct);
    chk("wait_cyc", 128'(cyc), 128'(74));
    chk("wait_hold", 128'(hold_bad), 128'(0));

    // start while busy and in the DONE cycle is dropped
    run(vt[0].pt, 0, 5, 40, 41, ct, cyc);
    repeat (10) @(negedge clk);
    chk("ign_ct", ct, vt[0].ct);
    chk("ign_cyc", 128'(cyc), 128'(41));
    chk("ign_done_n", 128'(done_n), 128'(1));
    chk("ign_busy", 128'(busy), 128'(0));

    // async reset during the round-6 ARK wait
    @(negedge clk);
    wait_n = 3; clr_counts(); data_in = vt[0].pt; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!(key_req && round_num == 4'd6) && cyc < 300) begin @(negedge clk); cyc++; end
    chk("abort_reached", 128'(round_num), 128'(6));
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_done", 128'(done), 128'(0));
    chk("abort_data", data_out, 128'(0));
    chk("abort_round", 128'(round_num), 128'(0));
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_done", 128'(done_n), 128'(0));
    run(vt[0].pt, 0, 0, 0, 0, ct, cyc);
    chk("after_abort_ct", ct, vt[0].ct);
    chk("after_abort_cyc", 128'(cyc), 128'(41));

    // single-round instance: KEY0, SUB, SHIFT, ARK, DONE
    @(negedge clk);
    data_in = vt[0].pt; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("nr1_seq%0d", c + 1), 128'({key_req1, sbe1, sre1, mce1, done1}),
          128'(sig_exp[c]));
      if (c == 4) chk("nr1_ct", data_out1, aes_ref(vt[0].pt, 1));
      @(negedge clk);
    end
    chk("nr1_idle", 128'(busy1), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
